lab1_imul_int_mul_var_param: RTL

- Parametrised, variable-latency iterative shift-add integer multiplier with val/rdy request and response interfaces. It succeeds the fixed 32-bit low-word multiplier.
- Adds three things over that multiplier: operand width as a parameter, RISC-V-style high-word modes (signed, unsigned, signed×unsigned), and multi-bit zero skipping bounded by a parameter.
- Sits behind a val/rdy source in the lab1 imul test harness and as the multiply unit of later processor labs.

---
 rtl/lab1_imul_int_mul_var_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lab1_imul_int_mul_var_param.sv
// Iterative shift-add multiplier with val/rdy handshakes, RISC-V high-word modes
// and zero skipping of up to MAX_SHAMT bits per cycle.
module lab1_imul_int_mul_var_param #(
    parameter int NBITS     = 32,
    parameter int MAX_SHAMT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2*NBITS+1:0] req_msg,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [NBITS-1:0]   resp_msg
);

    localparam int N  = NBITS;
    localparam int SW = $clog2(MAX_SHAMT + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_next;

    logic [2*N-1:0]        a_reg;
    logic [2*N-1:0]        acc;
    logic [N-1:0]          b_reg;
    logic                  neg;
    logic [1:0]            mode;

    logic [1:0]            req_mode;
    logic signed [N-1:0]   req_a;
    logic signed [N-1:0]   req_b;
    logic                  sa;
    logic                  sb;
    logic [N-1:0]          a_mag;
    logic [N-1:0]          b_mag;
    logic [2*N-1:0]        acc_fin;
    logic [SW-1:0]         shamt;

    // Trailing-zero count of b, capped at MAX_SHAMT; only used when b[0]==0 and b!=0.
    function automatic logic [SW-1:0] skip_amt(input logic [N-1:0] b);
        logic [SW-1:0] s;
        s = SW'(MAX_SHAMT);
        for (int i = MAX_SHAMT - 1; i >= 0; i--) begin
            if (b[i]) s = SW'(i);
        end
        return s;
    endfunction

    function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [N-1:0] pick_word(input logic [2*N-1:0] v, input logic [1:0] m);
        return (m == 2'b00) ? v[N-1:0] : v[2*N-1:N];
    endfunction

    assign req_mode = req_msg[2*N+1:2*N];
    assign req_a    = req_msg[2*N-1:N];
    assign req_b    = req_msg[N-1:0];

    // Only A is signed for MULH/MULHSU; only MULH treats B as signed.
    assign sa       = req_a[N-1] & req_mode[0];
    assign sb       = req_b[N-1] & (req_mode == 2'b01);
    assign a_mag    = sa ? -req_a : req_a;
    assign b_mag    = sb ? -req_b : req_b;
    assign acc_fin  = apply_sign(acc, neg);
    assign shamt    = skip_amt(b_reg);

    always_comb begin
        state_next = state;
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) state_next = CALC;
            end
            CALC: begin
                if (b_reg == '0) state_next = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            mode     <= 2'b00;
            resp_msg <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_val) begin
                        a_reg <= {{N{1'b0}}, a_mag};
                        b_reg <= b_mag;
                        acc   <= '0;
                        neg   <= sa ^ sb;
                        mode  <= req_mode;
                    end
                end
                CALC: begin
                    // Result word is captured here so it stays stable through DONE stalls.
                    if (b_reg == '0) begin
                        acc      <= acc_fin;
                        resp_msg <= pick_word(acc_fin, mode);
                    end else if (b_reg[0]) begin
                        acc   <= acc + a_reg;
                        b_reg <= b_reg >> 1;
                        a_reg <= a_reg << 1;
                    end else begin
                        b_reg <= b_reg >> shamt;
                        a_reg <= a_reg << shamt;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic string line_trace();
        string st;
        case (state)
            IDLE:    st = "I";
            CALC:    st = "C";
            DONE:    st = "D";
            default: st = "?";
        endcase
        return $sformatf("%b%b:%h (%s %h %h %h) %b%b:%h", req_val, req_rdy, req_msg,
                         st, a_reg, b_reg, acc, resp_val, resp_rdy, resp_msg);
    endfunction

endmodule
